// File: rtl/port_rx_buffer.sv
// rtl/port_rx_buffer.sv - per-port receive FIFO with packet framing, counters and routing checks
module port_rx_buffer #(
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  PORT_ADDR = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_out,
    input  logic [7:0]                 data_out,
    input  logic [7:0]                 addr_out,
    output logic                       data_rd,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic [7:0]                 m_addr,
    output logic                       m_sop,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                pkt_count,
    output logic                       misroute,
    output logic                       addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, IN_PKT} state_t;

    // Entry layout: {sop, addr[7:0], data[7:0]}
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    logic [7:0]    cur_addr;
    logic          push;
    logic          pop;
    logic          sop_bit;
    logic [16:0]   head;

    assign data_rd = !reset && (level < FULL_LEVEL);
    assign m_valid = (level != '0);
    assign push    = valid_out && data_rd;
    assign pop     = m_valid && m_ready;
    assign sop_bit = (state == IDLE);
    assign head    = mem[rd_ptr];

    // Head is gated so the stream reads zero whenever nothing is buffered
    assign m_sop  = m_valid && head[16];
    assign m_addr = m_valid ? head[15:8] : 8'h00;
    assign m_data = m_valid ? head[7:0]  : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sop_bit, addr_out, data_out};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= IDLE;
            cur_addr  <= 8'h00;
            pkt_count <= 16'h0000;
            misroute  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (push && (addr_out != PORT_ADDR)) begin
                misroute <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (push) begin
                        cur_addr <= addr_out;
                        if (pkt_count != 16'hFFFF) begin
                            pkt_count <= pkt_count + 16'h0001;
                        end
                        state <= IN_PKT;
                    end
                end
                IN_PKT: begin
                    // A stalled byte (valid but full) keeps the packet open
                    if (!valid_out) begin
                        state <= IDLE;
                    end else if (push && (addr_out != cur_addr)) begin
                        addr_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_rx_buffer.sv
// tb/tb_port_rx_buffer.sv - randomized self-checking bench for port_rx_buffer against a queue model
module tb_port_rx_buffer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] PA    = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_out = 1'b0;
    logic [7:0]  data_out = 8'h00;
    logic [7:0]  addr_out = 8'h00;
    logic        m_ready = 1'b0;
    logic        data_rd;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [7:0]  m_addr;
    logic        m_sop;
    logic [4:0]  level;
    logic [15:0] pkt_count;
    logic        misroute;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    port_rx_buffer #(.DEPTH(DEPTH), .PORT_ADDR(PA)) dut (
        .clk(clk), .reset(reset), .valid_out(valid_out), .data_out(data_out),
        .addr_out(addr_out), .data_rd(data_rd), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_addr(m_addr), .m_sop(m_sop), .level(level),
        .pkt_count(pkt_count), .misroute(misroute), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of {sop, addr, data} plus packet bookkeeping
    logic [16:0] q [$];
    bit          in_pkt = 0;
    logic [7:0]  cur = 8'h00;
    int          pkts = 0;
    bit          mis = 0;
    bit          aerr = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            in_pkt = 0;
            pkts = 0;
            mis = 0;
            aerr = 0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = valid_out && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && m_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (!in_pkt) begin
                    cur = addr_out;
                    if (pkts < 65535) pkts++;
                end else if (addr_out != cur) begin
                    aerr = 1;
                end
                if (addr_out != PA) mis = 1;
                q.push_back({!in_pkt, addr_out, data_out});
            end
            if (!valid_out) in_pkt = 0;
            else if (do_push) in_pkt = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("data_rd", 32'(data_rd), 32'(!reset && (q.size() < DEPTH)));
        check("m_valid", 32'(m_valid), 32'(q.size() != 0));
        check("level", 32'(level), 32'(q.size()));
        if (q.size() != 0) begin
            check("m_data", 32'(m_data), 32'(q[0][7:0]));
            check("m_addr", 32'(m_addr), 32'(q[0][15:8]));
            check("m_sop", 32'(m_sop), 32'(q[0][16]));
        end
        check("pkt_count", 32'(pkt_count), 32'(pkts));
        check("misroute", 32'(misroute), 32'(mis));
        check("addr_err", 32'(addr_err), 32'(aerr));
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic [7:0] a, input logic r);
        valid_out = v;
        data_out  = d;
        addr_out  = a;
        m_ready   = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'({m_sop, m_addr, m_data}), 32'd0);
        check("rst_data_rd", 32'(data_rd), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // Three-byte packet streamed straight through
        cyc(1, 8'h11, PA, 1);
        check("p1_b0", 32'({m_valid, m_sop, m_data}), {23'd0, 1'b1, 1'b1, 8'h11});
        cyc(1, 8'h22, PA, 1);
        check("p1_b1", 32'({m_valid, m_sop, m_data}), {23'd0, 1'b1, 1'b0, 8'h22});
        cyc(1, 8'h33, PA, 1);
        check("p1_b2", 32'({m_valid, m_sop, m_data}), {23'd0, 1'b1, 1'b0, 8'h33});
        cyc(0, 8'h00, PA, 1);
        check("p1_pkts", 32'(pkt_count), 32'd1);
        check("p1_flags", 32'({misroute, addr_err}), 32'd0);

        // Fill to full, then a single pop
        for (int i = 0; i < 20; i++) cyc(1, 8'(i + 8'h40), PA, 0);
        check("full_level", 32'(level), 32'd16);
        check("full_data_rd", 32'(data_rd), 32'd0);
        cyc(1, 8'hEE, PA, 1);
        check("pop1_level", 32'(level), 32'd15);
        check("pop1_data_rd", 32'(data_rd), 32'd1);
        cyc(0, 8'h00, PA, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, PA, 1);
        check("drained", 32'(level), 32'd0);

        // Two packets separated by a one-cycle gap
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + 8'(p * 4 + i)), PA, 1);
            cyc(0, 8'h00, PA, 1);
        end
        check("two_pkts", 32'(pkt_count), 32'd4);

        // Misroute, then address change inside a packet
        cyc(1, 8'h55, PA ^ 8'h01, 1);
        check("misroute_data", 32'({m_valid, m_data}), {23'd0, 1'b1, 8'h55});
        cyc(0, 8'h00, PA, 1);
        check("misroute_set", 32'({misroute, addr_err}), 32'b10);
        cyc(1, 8'h56, 8'h00, 1);
        cyc(1, 8'h57, 8'h02, 1);
        cyc(0, 8'h00, PA, 1);
        check("addr_err_set", 32'({misroute, addr_err}), 32'b11);

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), PA, 0);
        check("lvl5", 32'(level), 32'd5);
        cyc(1, 8'h85, PA, 1);
        check("lvl5_pushpop", 32'(level), 32'd5);
        cyc(0, 8'h00, PA, 1);

        // Randomized traffic, long enough to wrap the pointers many times
        for (int i = 0; i < 600; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : PA;
            cyc(($urandom_range(0, 9) < 7), 8'($urandom), a, ($urandom_range(0, 9) < 5));
        end
        check("sticky_end", 32'({misroute, addr_err}), 32'b11);

        // Asynchronous reset mid-packet at level 7
        for (int i = 0; i < 20; i++) cyc(0, 8'h00, PA, 1);
        for (int i = 0; i < 7; i++) cyc(1, 8'(8'hA0 + i), PA, 0);
        check("pre_rst_level", 32'(level), 32'd7);
        reset = 1'b1;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        cyc(1, 8'h77, PA, 0);
        check("post_rst_sop", 32'({m_valid, m_sop, m_data}), {23'd0, 1'b1, 1'b1, 8'h77});
        check("post_rst_pkts", 32'(pkt_count), 32'd1);
        check("post_rst_flags", 32'({misroute, addr_err}), 32'd0);
        cyc(0, 8'h00, PA, 1);
        cyc(0, 8'h00, PA, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_rx_buffer.md
Name: port_rx_buffer

Overview:
- Per-port receive buffer sitting directly downstream of one output port of the 4-port switch.
- Pulls bytes from the switch via the valid_out/data_rd handshake and stores {addr, data, sop} entries in a FIFO.
- Re-presents the entries to the next stage on a ready/valid stream.
- Counts received packets and flags misrouted or address-inconsistent traffic.
- Four instances are used, one per switch output lane (bit i of valid_out/data_rd, byte i of data_out/addr_out).

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
PORT_ADDR, 8'h00, expected addr_out value for this lane; any other value is a misroute.

Ports:
clk  input  1  system clock; all state on its rising edge
reset  input  1  asynchronous, active-high reset
valid_out  input  1  switch lane has a byte presented
data_out  input  8  switch lane data byte
addr_out  input  8  switch lane address byte
data_rd  output  1  buffer accepts the presented byte this cycle
m_valid  output  1  stream entry valid
m_ready  input  1  downstream accepts entry
m_data  output  8  stream data byte
m_addr  output  8  stream address byte
m_sop  output  1  entry is the first byte of a packet
level  output  $clog2(DEPTH)+1  current FIFO occupancy
pkt_count  output  16  packets received; saturates at 16'hFFFF
misroute  output  1  sticky: a byte arrived with addr_out != PORT_ADDR
addr_err  output  1  sticky: addr_out changed inside a packet

Behaviour:
- Reset (async assert, sync-release use):
  - FIFO empties; level=0; m_valid=0; pkt_count=0; misroute=0; addr_err=0; state=IDLE.
  - m_data, m_addr and m_sop read 0.
- data_rd = !reset && (level < DEPTH). It is combinational from registered state only; no input-to-output path.
- Push: occurs at a rising edge where valid_out && data_rd. The entry written is {addr_out, data_out, sop}.
- Packet framing FSM:
  - IDLE: push writes sop=1, latches addr_out into cur_addr, increments pkt_count, goes to IN_PKT.
  - IN_PKT, valid_out=1: a push writes sop=0. If addr_out != cur_addr, set addr_err; cur_addr is not updated. If valid_out=1 but data_rd=0 (full), hold in IN_PKT with no push.
  - IN_PKT, valid_out=0 at an edge: packet ends; return to IDLE.
- Misroute: any push with addr_out != PORT_ADDR sets misroute. The byte is still stored.
- Pop: occurs at an edge where m_valid && m_ready.
  - m_valid = (level != 0).
  - m_data, m_addr and m_sop show the head entry. They hold stable while m_valid && !m_ready.
- Latency: a byte pushed at edge N is visible at the head at earliest after edge N (m_valid high in cycle N+1). There is no bypass.
- Simultaneous push and pop: both occur. level is unchanged and the pointers advance.
  - Full (level=DEPTH): data_rd=0, so no push; a pop is still allowed. data_rd rises in the cycle after the pop.
  - Empty: m_valid=0 and a push is allowed.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. level is tracked separately, range 0..DEPTH.
- pkt_count: saturates at 16'hFFFF; it does not wrap.
- misroute and addr_err: cleared only by reset.
- Reset mid-packet: the FIFO contents and the partial packet are discarded. The first byte after release is treated as sop=1.

Test Plan:
- Reset, then valid_out=1 for 3 bytes 11,22,33 with addr_out=PORT_ADDR, m_ready=1 -> stream shows 11(sop=1),22,33 one cycle after each push; pkt_count=1; flags stay 0.
- m_ready=0 and continuous valid_out with DEPTH=16 -> 16 bytes accepted, then data_rd=0 and level=16. Raise m_ready for 1 cycle -> exactly one pop, and data_rd=1 on the next cycle.
- Two packets separated by a one-cycle valid_out gap -> pkt_count=2; m_sop=1 on byte 0 of each packet only.
- Byte with addr_out=PORT_ADDR^8'h01 -> misroute=1, byte still delivered. Inside a packet, change addr_out 8'h00->8'h02 -> addr_err=1. Both remain 1 until reset.
- Push and pop in the same cycle at level=5 -> level remains 5. Run 40 bytes through DEPTH=16 -> order preserved across pointer wrap.
- Assert reset mid-packet with level=7 -> level=0 and m_valid=0 immediately (asynchronous). After release, the next byte has sop=1 and pkt_count=1.
